// File: rtl/wdg_sched_pkg.sv
// Shared types and constants for the watchdog feed scheduler.
// Step table maps the 4-write unlock/feed sequence to {offset, data}.
package wdg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SETUP,
    ACCESS
  } state_t;

  localparam logic [31:0] WDG_KEY_VAL   = 32'h5F3759DF;
  localparam logic [31:0] KEY_OFFS_DEF  = 32'h14;
  localparam logic [31:0] FEED_OFFS_DEF = 32'h18;

  typedef struct packed {
    logic [31:0] offs;
    logic [31:0] data;
  } wr_t;

  // KEY precedes each FEED write; FEED goes 1 then back to 0
  function automatic wr_t step_wr(
    input logic [1:0]  step,
    input logic [31:0] key_offs,
    input logic [31:0] feed_offs
  );
    wr_t w;
    unique case (step)
      2'd0, 2'd2: w = '{offs: key_offs, data: WDG_KEY_VAL};
      2'd1:       w = '{offs: feed_offs, data: 32'd1};
      default:    w = '{offs: feed_offs, data: 32'd0};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/apb4_wr_mst.sv
// Single APB4 write engine: start pulse is the SETUP phase,
// then ACCESS holds latched addr/data until pready_i.
module apb4_wr_mst (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic        psel_o,
  output logic        penable_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  output logic        done_o,
  output logic        err_o
);

  logic        acc_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (start_i && !acc_q) begin
      acc_q  <= 1'b1;
      addr_q <= addr_i;
      data_q <= data_i;
    end else if (acc_q && pready_i) begin
      acc_q  <= 1'b0;
    end
  end

  assign psel_o    = start_i | acc_q;
  assign penable_o = acc_q;
  // Bus is driven to zero when not selected
  assign paddr_o   = acc_q ? addr_q : (start_i ? addr_i : '0);
  assign pwdata_o  = acc_q ? data_q : (start_i ? data_i : '0);
  assign done_o    = acc_q & pready_i & ~pslverr_i;
  assign err_o     = acc_q & pready_i & pslverr_i;

endmodule

// File: rtl/wdg_feed_sched.sv
// Multi-client watchdog feed scheduler with APB4 master.
// Optional min-window check-in filter: WDG_SCHED_WINDOW_EN.
module wdg_feed_sched
  import wdg_sched_pkg::*;
#(
  parameter int          N_CLI     = 4,
  parameter int          TMO_W     = 32,
  parameter logic [31:0] KEY_OFFS  = KEY_OFFS_DEF,
  parameter logic [31:0] FEED_OFFS = FEED_OFFS_DEF,
  parameter int          MIN_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [N_CLI-1:0] mask_i,
  input  logic [TMO_W-1:0] tmo_i,
  input  logic [31:0]      base_i,
  input  logic [N_CLI-1:0] chk_i,
  input  logic             miss_clr_i,
`ifdef WDG_SCHED_WINDOW_EN
  input  logic [MIN_W-1:0] min_i,
  output logic [N_CLI-1:0] early_o,
`endif
  output logic [N_CLI-1:0] miss_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             fed_o,
  output logic [31:0]      paddr_o,
  output logic             psel_o,
  output logic             penable_o,
  output logic             pwrite_o,
  output logic [31:0]      pwdata_o,
  input  logic             pready_i,
  input  logic             pslverr_i
);

  if (N_CLI < 1 || N_CLI > 16 || MIN_W < 1) begin : g_bad_param
    $error("wdg_feed_sched: parameter out of range");
  end

  state_t           state_q, state_d;
  logic [N_CLI-1:0] seen_q, miss_q, chk_ok;
  logic [TMO_W-1:0] cnt_q, tmo_m1;
  logic [1:0]       step_q;
  logic             err_q, fed_q;
  logic             all_in, in_col, to_setup, timeout;
  logic             wr_done, wr_err, last;
  wr_t              wr;

  assign wr       = step_wr(step_q, KEY_OFFS, FEED_OFFS);
  assign tmo_m1   = (tmo_i == '0) ? '0 : tmo_i - 1'b1;
  assign all_in   = &(seen_q | ~mask_i);
  assign in_col   = (state_q == COLLECT) && en_i;
  // Completion beats a timeout landing in the same cycle
  assign to_setup = in_col && all_in;
  assign timeout  = in_col && !all_in && (cnt_q >= tmo_m1);
  assign last     = (step_q == 2'd3);

`ifdef WDG_SCHED_WINDOW_EN
  logic [MIN_W-1:0] win_q;
  logic [N_CLI-1:0] early_q;
  logic             too_early;

  assign too_early = win_q < min_i;
  assign chk_ok    = too_early ? '0 : chk_i;
  assign early_o   = early_q;

  // Reset value is all-ones so the window starts open
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_q   <= '1;
      early_q <= '0;
    end else begin
      if (fed_q)
        win_q <= '0;
      else if (too_early)
        win_q <= win_q + 1'b1;
      early_q <= (early_q & ~{N_CLI{miss_clr_i}})
               | (too_early ? chk_i : '0);
    end
  end
`else
  assign chk_ok = chk_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (en_i) state_d = COLLECT;
      COLLECT:
        if (!en_i)       state_d = IDLE;
        else if (all_in) state_d = SETUP;
      SETUP:
        state_d = ACCESS;
      ACCESS:
        if (wr_err || (wr_done && last))
          state_d = en_i ? COLLECT : IDLE;
        else if (wr_done)
          state_d = SETUP;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seen_q <= '0;
      miss_q <= '0;
      cnt_q  <= '0;
      step_q <= '0;
      err_q  <= 1'b0;
      fed_q  <= 1'b0;
    end else begin
      seen_q <= ((to_setup || timeout) ? '0 : seen_q) | chk_ok;
      cnt_q  <= (in_col && !to_setup && !timeout) ? cnt_q + 1'b1 : '0;
      miss_q <= (miss_q & ~{N_CLI{miss_clr_i}})
              | (timeout ? (mask_i & ~seen_q) : '0);
      err_q  <= (err_q & ~miss_clr_i) | wr_err;
      fed_q  <= wr_done && last;
      if (wr_err)
        step_q <= '0;
      else if (wr_done)
        step_q <= step_q + 2'd1;
    end
  end

  apb4_wr_mst u_mst (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (state_q == SETUP),
    .addr_i    (base_i + wr.offs),
    .data_i    (wr.data),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .done_o    (wr_done),
    .err_o     (wr_err)
  );

  assign miss_o   = miss_q;
  assign err_o    = err_q;
  assign fed_o    = fed_q;
  assign busy_o   = (state_q == SETUP) || (state_q == ACCESS);
  assign pwrite_o = 1'b1;

endmodule

// File: tb/tb_wdg_feed_sched.sv
// Bench for wdg_feed_sched: vector table, corner sequences,
// and randomized check-ins against a round-level model.
module tb_wdg_feed_sched;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] KOFF = 32'h14;
  localparam logic [31:0] FOFF = 32'h18;
  localparam logic [31:0] KEYV = 32'h5F3759DF;

  logic        clk = 1'b0;
  logic        rst_i, en_i, miss_clr_i;
  logic [3:0]  mask_i, chk_i, miss_o;
  logic [31:0] tmo_i, base_i, paddr_o, pwdata_o;
  logic        err_o, busy_o, fed_o;
  logic        psel_o, penable_o, pwrite_o;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  always #5 clk = ~clk;

  wdg_feed_sched dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .mask_i(mask_i), .tmo_i(tmo_i), .base_i(base_i),
    .chk_i(chk_i), .miss_clr_i(miss_clr_i),
    .miss_o(miss_o), .err_o(err_o), .busy_o(busy_o),
    .fed_o(fed_o), .paddr_o(paddr_o), .psel_o(psel_o),
    .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pready_i(pready_i),
    .pslverr_i(pslverr_i)
  );

  int n_chk = 0, n_pass = 0;
  int wait_cfg = 0, err_at = -1;
  int n_wr = 0, fed_cnt = 0, busy_cnt = 0, wc = 0;
  bit in_acc = 0;
  logic [31:0] sav_a, sav_d;
  logic [63:0] wr_log[$];
  int b_wr, b_fed, b_busy;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Slave + monitor: pready decided mid-cycle for the next edge
  always @(negedge clk) begin
    if (fed_o) fed_cnt++;
    if (busy_o) busy_cnt++;
    if (psel_o && penable_o) begin
      if (!in_acc) begin
        in_acc = 1; sav_a = paddr_o; sav_d = pwdata_o; wc = 0;
      end else begin
        check("hold_paddr", paddr_o, sav_a);
        check("hold_pwdata", pwdata_o, sav_d);
      end
      if (wc < wait_cfg) begin
        pready_i = 0; pslverr_i = 0; wc++;
      end else begin
        pready_i = 1; pslverr_i = (n_wr == err_at);
        wr_log.push_back({paddr_o, pwdata_o});
        n_wr++; in_acc = 0;
      end
    end else begin
      pready_i = 0; pslverr_i = 0; in_acc = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_i = 1; en_i = 0; chk_i = 0; miss_clr_i = 0;
    tick(); tick();
    rst_i = 0;
    b_wr = n_wr; b_fed = fed_cnt; b_busy = busy_cnt;
  endtask

  task automatic wait_busy(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (busy_o) break;
      tick();
    end
    check("busy_start", busy_o, 1);
  endtask

  task automatic check_seq(input int b);
    logic [63:0] e[4];
    e[0] = {BASE + KOFF, KEYV};
    e[1] = {BASE + FOFF, 32'd1};
    e[2] = {BASE + KOFF, KEYV};
    e[3] = {BASE + FOFF, 32'd0};
    for (int i = 0; i < 4; i++) begin
      if (b + i < wr_log.size())
        check($sformatf("seq_wr%0d", i), wr_log[b + i], e[i]);
      else
        check($sformatf("seq_wr%0d_missing", i), 0, 1);
    end
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  chk;
    logic [31:0] tmo;
    int          cyc;
    int          fed;
    int          wr;
    logic [3:0]  miss;
    logic        busy;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    logic [3:0] c, nm, m_seen, m_miss;
    bit clr, m_idle, m_fed;
    int m_el, m_left, m_wr, teff;

    mask_i = 4'hF; tmo_i = 1000; base_i = BASE;
    do_reset();
    check("rst_miss", miss_o, 0);
    check("rst_err", err_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_fed", fed_o, 0);
    check("rst_psel", psel_o, 0);
    check("rst_penable", penable_o, 0);
    check("rst_paddr", paddr_o, 0);
    check("rst_pwdata", pwdata_o, 0);

    tbl[0] = '{4'hF, 4'hF, 1000, 30, 1, 4, 4'h0, 0};
    tbl[1] = '{4'h5, 4'h5, 1000, 30, 1, 4, 4'h0, 0};
    tbl[2] = '{4'h5, 4'h2, 1000, 30, 0, 0, 4'h0, 0};
    tbl[3] = '{4'hF, 4'h7, 20,   30, 0, 0, 4'h8, 0};
    tbl[4] = '{4'h1, 4'h1, 0,    30, 1, 4, 4'h1, 0};
    tbl[5] = '{4'h3, 4'h3, 1,    30, 1, 4, 4'h3, 0};
    tbl[6] = '{4'h3, 4'h3, 2,    1,  0, 0, 4'h0, 1};
    for (int r = 0; r < 7; r++) begin
      do_reset();
      mask_i = tbl[r].mask; tmo_i = tbl[r].tmo;
      en_i = 1; tick();
      chk_i = tbl[r].chk; tick(); chk_i = 0;
      repeat (tbl[r].cyc) tick();
      check($sformatf("tbl%0d_fed", r), fed_cnt - b_fed, tbl[r].fed);
      check($sformatf("tbl%0d_wr", r), n_wr - b_wr, tbl[r].wr);
      check($sformatf("tbl%0d_miss", r), miss_o, tbl[r].miss);
      check($sformatf("tbl%0d_busy", r), busy_o, tbl[r].busy);
    end

    // Staggered check-ins, single feed sequence
    do_reset();
    mask_i = 4'hF; tmo_i = 100;
    en_i = 1; tick();
    for (int k = 0; k < 40; k++) begin
      chk_i = 0;
      if (k >= 5 && k <= 20 && k % 5 == 0) chk_i[k / 5 - 1] = 1'b1;
      if (k == 20) check("t1_nofeed_early", fed_cnt - b_fed, 0);
      tick();
    end
    chk_i = 0;
    check("t1_wr", n_wr - b_wr, 4);
    check_seq(b_wr);
    check("t1_fed", fed_cnt - b_fed, 1);
    check("t1_busy_cycles", busy_cnt - b_busy, 8);

    // Timeout with one client absent, then clear
    do_reset();
    mask_i = 4'hF; tmo_i = 50;
    en_i = 1; tick();
    for (int k = 0; k < 50; k++) begin
      chk_i = (k == 3) ? 4'h7 : 4'h0;
      if (k == 49) check("t3_miss_before", miss_o, 0);
      tick();
    end
    chk_i = 0;
    check("t3_miss", miss_o, 4'h8);
    check("t3_nowr", n_wr - b_wr, 0);
    miss_clr_i = 1; tick(); miss_clr_i = 0;
    check("t3_miss_clr", miss_o, 0);

    // Wait-state slave
    do_reset();
    wait_cfg = 3; mask_i = 4'hF; tmo_i = 1000;
    en_i = 1; tick();
    chk_i = 4'hF; tick(); chk_i = 0;
    repeat (30) tick();
    check("t4_wr", n_wr - b_wr, 4);
    check_seq(b_wr);
    check("t4_fed", fed_cnt - b_fed, 1);
    check("t4_busy_cycles", busy_cnt - b_busy, 20);
    wait_cfg = 0;

    // Slave error on the FEED=1 write aborts the round
    do_reset();
    mask_i = 4'hF; tmo_i = 1000;
    err_at = n_wr + 1;
    en_i = 1; tick();
    chk_i = 4'hF; tick(); chk_i = 0;
    repeat (20) tick();
    check("t5_err", err_o, 1);
    check("t5_wr", n_wr - b_wr, 2);
    check("t5_fed", fed_cnt - b_fed, 0);
    check("t5_busy", busy_o, 0);
    err_at = -1;
    chk_i = 4'hF; tick(); chk_i = 0;
    repeat (12) tick();
    check("t5_refeed", fed_cnt - b_fed, 1);
    check_seq(b_wr + 2);
    check("t5_err_held", err_o, 1);
    miss_clr_i = 1; tick(); miss_clr_i = 0;
    check("t5_err_clr", err_o, 0);

    // Enable drop mid-sequence; check-ins on the last cycle
    do_reset();
    mask_i = 4'hF; tmo_i = 1000;
    en_i = 1; tick();
    chk_i = 4'hF; tick(); chk_i = 0;
    wait_busy(20);
    tick(); tick();
    en_i = 0;
    repeat (5) tick();
    chk_i = 4'hF; tick(); chk_i = 0;
    check("t6_fed_pulse", fed_o, 1);
    check("t6_wr", n_wr - b_wr, 4);
    repeat (10) tick();
    check("t6_idle_nofeed", fed_cnt - b_fed, 1);
    check("t6_idle_busy", busy_o, 0);
    en_i = 1;
    wait_busy(5);
    repeat (10) tick();
    check("t6_seen_kept_feed", fed_cnt - b_fed, 2);
    check("t6_wr2", n_wr - b_wr, 8);

    // Reset during an ACCESS wait
    do_reset();
    wait_cfg = 3; mask_i = 4'hF; tmo_i = 1000;
    en_i = 1; tick();
    chk_i = 4'hF; tick(); chk_i = 0;
    wait_busy(10);
    tick();
    check("tr_access", {psel_o, penable_o}, 2'b11);
    rst_i = 1; tick();
    check("tr_psel", psel_o, 0);
    check("tr_penable", penable_o, 0);
    rst_i = 0; wait_cfg = 0;

    // Randomized check-ins against a round-level model
    for (int run = 0; run < 3; run++) begin
      do_reset();
      mask_i = 4'($urandom_range(0, 15));
      tmo_i = (run == 0) ? 0 :
              (run == 1) ? $urandom_range(1, 12) : $urandom_range(13, 40);
      teff = (tmo_i == 0) ? 1 : int'(tmo_i);
      m_idle = 1; m_seen = 0; m_el = 0; m_left = 0;
      m_miss = 0; m_wr = 0;
      en_i = 1;
      for (int k = 0; k < 250; k++) begin
        for (int i = 0; i < 4; i++) c[i] = ($urandom_range(0, 3) == 0);
        clr = ($urandom_range(0, 19) == 0);
        chk_i = c; miss_clr_i = clr;
        m_fed = 0; nm = 0;
        if (m_idle) begin
          m_idle = 0; m_seen |= c;
        end else if (m_left > 0) begin
          m_left--;
          if (m_left % 2 == 0) m_wr++;
          if (m_left == 0) m_fed = 1;
          m_seen |= c;
        end else if ((m_seen | ~mask_i) == 4'hF) begin
          m_left = 8; m_seen = c; m_el = 0;
        end else if (m_el >= teff - 1) begin
          nm = mask_i & ~m_seen; m_seen = c; m_el = 0;
        end else begin
          m_el++; m_seen |= c;
        end
        m_miss = (clr ? 4'h0 : m_miss) | nm;
        tick();
        check($sformatf("rnd%0d_busy@%0d", run, k), busy_o, m_left > 0);
        check($sformatf("rnd%0d_miss@%0d", run, k), miss_o, m_miss);
        check($sformatf("rnd%0d_fed@%0d", run, k), fed_o, m_fed);
      end
      chk_i = 0; miss_clr_i = 0;
      check($sformatf("rnd%0d_wr", run), n_wr - b_wr, m_wr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
